// File: rtl/alu_seq.sv
// alu_seq: registered ALU with persistent CLFZN flag register and one-bit-per-cycle shifts.
// Defining ALU_MUL_EN adds an unsigned shift-add MUL (1010_1000).
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [3:0]       opext,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             flag_ld,
  input  logic [4:0]       flag_in,
  output logic [WIDTH-1:0] S,
  output logic             out_valid,
  output logic             res_we,
  output logic [4:0]       CLFZN
);
  localparam int CW = (SHW > 6) ? SHW : 6;
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d, sh_q, sh_d, sh_nx, res;
  logic [4:0] flags_q, flags_d, fl;
  logic ov_q, ov_d, we_q, we_d, we, keep, is_sh, accept;
  logic [1:0] shk_q, shk_d, shk;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] sum_n, sum_c, dif;
  logic [SHW-1:0] k;
  logic add_v, addc_v, sub_v;
`ifdef ALU_MUL_EN
  logic is_mul;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_nx;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH:0] msum;
`endif
  assign in_ready = state_q == IDLE;
  assign accept = in_valid && in_ready;
  assign k = B[SHW-1:0];
  assign sum_n = {1'b0, A} + {1'b0, B};
  assign sum_c = sum_n + {{WIDTH{1'b0}}, flags_q[4]};
  assign dif = {1'b0, A} - {1'b0, B};
  assign add_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum_n[WIDTH-1] != A[WIDTH-1]);
  assign addc_v = (A[WIDTH-1] == B[WIDTH-1]) && (sum_c[WIDTH-1] != A[WIDTH-1]);
  assign sub_v = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
  assign sh_nx = shk_q == 2'd0 ? sh_q << 1 :
                 shk_q == 2'd1 ? sh_q >> 1 : {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
`ifdef ALU_MUL_EN
  assign msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nx = {msum, prod_q[WIDTH-1:1]};
`endif
  assign S = s_q;
  assign out_valid = ov_q;
  assign res_we = we_q;
  assign CLFZN = flags_q;
  // Decode: explicit encodings are listed before the opcode-only wildcards so they win.
  always_comb begin
    res = '0;
    we = 1'b1;
    keep = 1'b0;
    fl = flags_q;
    is_sh = 1'b0;
    shk = 2'd0;
`ifdef ALU_MUL_EN
    is_mul = 1'b0;
`endif
    casez ({opcode, opext})
      8'b0000_0101, 8'b0101_????: begin
        res = sum_n[WIDTH-1:0];
        fl[2] = add_v;
        fl[1] = ~|sum_n[WIDTH-1:0];
      end
      8'b0000_0110, 8'b0110_????: begin
        res = sum_n[WIDTH-1:0];
        fl[4] = sum_n[WIDTH];
        fl[1] = ~|sum_n[WIDTH-1:0];
      end
      8'b0000_0111, 8'b0111_????: begin
        res = sum_c[WIDTH-1:0];
        fl[4] = sum_c[WIDTH];
        fl[2] = addc_v;
        fl[1] = ~|sum_c[WIDTH-1:0];
      end
      8'b1010_0101, 8'b1010_0110: begin
        res = sum_c[WIDTH-1:0];
        fl[4] = sum_c[WIDTH];
        fl[1] = ~|sum_c[WIDTH-1:0];
      end
      8'b0000_1001, 8'b1001_????: begin
        res = dif[WIDTH-1:0];
        fl[4] = dif[WIDTH];
        fl[2] = sub_v;
        fl[1] = ~|dif[WIDTH-1:0];
      end
      8'b0000_1011, 8'b1011_????, 8'b1010_0010: begin
        we = 1'b0;
        keep = 1'b1;
        fl[3] = A < B;
        fl[1] = A == B;
        fl[0] = $signed(A) < $signed(B);
      end
      8'b0000_0001: res = A & B;
      8'b0000_0010: res = A | B;
      8'b0000_0011: res = A ^ B;
      8'b1010_0011: res = ~A;
      8'b0000_1101, 8'b1101_????: res = B;
      8'b1000_????, 8'b1010_0001: begin
        res = A;
        is_sh = 1'b1;
      end
      8'b0000_1110, 8'b1110_????: begin
        res = A;
        is_sh = 1'b1;
        shk = 2'd1;
      end
      8'b1010_0100: begin
        res = A;
        is_sh = 1'b1;
        shk = 2'd2;
      end
`ifdef ALU_MUL_EN
      8'b1010_1000: is_mul = 1'b1;
`endif
      default: we = 1'b0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    flags_d = flags_q;
    ov_d = 1'b0;
    we_d = 1'b0;
    sh_d = sh_q;
    shk_d = shk_q;
    cnt_d = cnt_q;
`ifdef ALU_MUL_EN
    prod_d = prod_q;
    mcand_d = mcand_q;
`endif
    if (state_q == IDLE && accept) begin
      if (is_sh && k != '0) begin
        state_d = SHIFT;
        sh_d = A;
        shk_d = shk;
        cnt_d = CW'(k);
      end
`ifdef ALU_MUL_EN
      else if (is_mul) begin
        state_d = MUL;
        prod_d = {{WIDTH{1'b0}}, B};
        mcand_d = A;
        cnt_d = CW'(WIDTH);
      end
`endif
      else begin
        s_d = keep ? s_q : res;
        flags_d = fl;
        ov_d = 1'b1;
        we_d = we;
      end
    end
    if (state_q == SHIFT) begin
      sh_d = sh_nx;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        s_d = sh_nx;
        ov_d = 1'b1;
        we_d = 1'b1;
      end
    end
`ifdef ALU_MUL_EN
    if (state_q == MUL) begin
      prod_d = prod_nx;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        s_d = prod_nx[WIDTH-1:0];
        flags_d[4] = |prod_nx[2*WIDTH-1:WIDTH];
        flags_d[1] = ~|prod_nx[WIDTH-1:0];
        ov_d = 1'b1;
        we_d = 1'b1;
      end
    end
`endif
    if (flag_ld) flags_d = flag_in;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      s_q <= '0;
      flags_q <= '0;
      ov_q <= 1'b0;
      we_q <= 1'b0;
      sh_q <= '0;
      shk_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      flags_q <= flags_d;
      ov_q <= ov_d;
      we_q <= we_d;
      sh_q <= sh_d;
      shk_q <= shk_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef ALU_MUL_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      prod_q <= '0;
      mcand_q <= '0;
    end else begin
      prod_q <= prod_d;
      mcand_q <= mcand_d;
    end
  end
`endif
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, registered successor to the combinational 16-bit ALU, sitting between register-file read and write-back in the CPU datapath. It keeps the same 8-bit {opcode, opext} encoding and CLFZN flag layout. It adds a persistent processor-status flag register, so ADDC/ADDCI consume the stored carry. Shifts by a variable amount are multi-cycle behind a valid/ready handshake.

Parameters:
WIDTH, 16, datapath width in bits (8..32).
SHW, 4, shift-amount field width; the amount is B[SHW-1:0], and 2**SHW must be >= WIDTH.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
in_valid  input  1  operation request
in_ready  output  1  high when able to accept an operation (IDLE)
opcode  input  4  primary opcode
opext  input  4  opcode extension
A  input  WIDTH  operand A (Rdest)
B  input  WIDTH  operand B (Rsrc, or sign-/zero-extended immediate)
flag_ld  input  1  load flag register from flag_in (LPR / interrupt restore)
flag_in  input  5  flag value for flag_ld
S  output  WIDTH  registered result, held until the next completion
out_valid  output  1  one-cycle pulse: S valid and write-back enabled
res_we  output  1  qualifies out_valid; 0 for CMP/CMPI/unknown ops (no register write)
CLFZN  output  5  flag register: [4]C [3]L [2]F [1]Z [0]N

Behaviour:
- Reset (synchronous): state=IDLE, S=0, out_valid=0, res_we=0, CLFZN=0, in_ready=1. A reset mid-shift aborts the operation with no out_valid pulse.
- Accept: an operation is accepted when in_valid && in_ready. Operands and op are latched at accept; input changes afterwards are ignored.
- States:
  - IDLE: in_ready=1. On accept of a single-cycle op, compute and register S and flags; out_valid pulses on the next cycle (latency 1). On accept of a shift with k=B[SHW-1:0]: if k=0, latency 1 and S=A; if k>0, go to SHIFT with cnt=k.
  - SHIFT: in_ready=0. Shift one bit per cycle and decrement cnt. When cnt reaches 0, register S, pulse out_valid, and return to IDLE. Latency is 1+k cycles. k >= WIDTH yields 0 (logical/left) or all sign bits (ARSH).
- Ops and flag effects. All arithmetic is mod 2^WIDTH. N and L are written only by the ops listed.
  - ADD 0000_0101, ADDI 0101_xxxx: S=A+B; F=signed overflow; Z=(S==0); C unchanged.
  - ADDU 0000_0110, ADDUI 0110_xxxx: S=A+B; C=carry out; Z; F unchanged.
  - ADDC 0000_0111, ADDCI 0111_xxxx: S=A+B+C_reg; C=carry out; F; Z.
  - ADDCU 1010_0101, ADDCUI 1010_0110: S=A+B+C_reg; C=carry out; Z.
  - SUB 0000_1001, SUBI 1001_xxxx: S=A-B; C=borrow (A<B unsigned); F=overflow; Z.
  - CMP 0000_1011, CMPI 1011_xxxx, CMPU 1010_0010: res_we=0 and S unchanged; Z=(A==B); L=(A<B unsigned); N=(A<B signed). C and F are unchanged.
  - AND/OR/XOR 0000_0001/0010/0011, NOT 1010_0011, MOV 0000_1101, MOVI 1101_xxxx: S computed; flags unchanged.
  - LSH 1000_0100, LSHI 1000_xxxx, ALSH 1010_0001: left shift by k.
  - RSH 0000_1110, RSHI 1110_xxxx: logical right shift by k.
  - ARSH 1010_0100: arithmetic right shift by k (sign-fill).
  - Explicit opcodes take priority over xxxx wildcards; for example, 1000_0100 is LSH.
  - Unknown encoding: S=0, res_we=0, flags unchanged, latency 1.
- flag_ld: CLFZN<=flag_in on the next edge. If an op completes in the same cycle, flag_ld wins for all five bits.
- Back-to-back: a new op may be accepted in the same cycle out_valid pulses from the previous one. ADDC uses C as updated by the immediately preceding op (no hazard).

Optional Feature:
ALU_MUL_EN: when defined, adds MUL 1010_1000, an unsigned shift-add multiply that runs in a MUL state for WIDTH cycles, with in_ready=0. It produces S = low WIDTH bits of A*B and sets Z, with C=1 if the high half is nonzero; latency is WIDTH+1. When undefined, 1010_1000 decodes as unknown, and no MUL state or logic exists.

Test Plan:
- Reset, then ADDU A=FFFF B=0001 -> after 1 cycle S=0000, C=1, Z=1; then ADDC A=0001 B=0001 -> S=0003, C=0.
- ADD A=7FFF B=0001 -> S=8000, F=1, Z=0; SUB A=8000 B=0001 -> S=7FFF, F=1, C=0.
- CMP A=0001 B=FFFF -> res_we=0, S unchanged, L=1, N=0, Z=0; CMPI A=0005 B=0005 -> Z=1.
- ARSH A=8000 B=0004 -> in_ready low 4 cycles, out_valid at accept+5, S=F800; LSH k=0 A=1234 -> S=1234 at latency 1.
- Assert reset during the 3rd cycle of a 10-bit RSH -> no out_valid, S=0, CLFZN=0, in_ready=1 the following cycle.
- flag_ld=1 flag_in=10000 in the same cycle an ADD completes with Z=1 -> CLFZN=10000; then ADDC A=0 B=0 -> S=0001.
